// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural register file plus rename-status table fed by the ROB commit bus
// Optional debug read port and busy mask enabled by defining REGFILE_DEBUG_PORT_EN.
module reg_status_file #(
  parameter int REG_NUM    = 32,
  parameter int REG_WIDTH  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  clear,
  input  logic                  ID_rename_valid,
  input  logic [REG_WIDTH-1:0]  ID_rename_reg,
  input  logic [TAG_WIDTH-1:0]  ID_rename_tag,
  input  logic [REG_WIDTH-1:0]  ID_rs1,
  input  logic [REG_WIDTH-1:0]  ID_rs2,
  output logic                  reg1_busy,
  output logic [TAG_WIDTH-1:0]  reg1_tag,
  output logic [DATA_WIDTH-1:0] reg1_data,
  output logic                  reg2_busy,
  output logic [TAG_WIDTH-1:0]  reg2_tag,
  output logic [DATA_WIDTH-1:0] reg2_data,
  input  logic                  CDB_data_valid,
  input  logic [REG_WIDTH-1:0]  CDB_reg_dest,
  input  logic [TAG_WIDTH-1:0]  CDB_tag,
  input  logic [DATA_WIDTH-1:0] CDB_data
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [REG_WIDTH-1:0]  dbg_reg_addr,
  output logic [DATA_WIDTH-1:0] dbg_reg_data,
  output logic [REG_NUM-1:0]    dbg_busy_mask
`endif
);

  logic [REG_NUM-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [REG_NUM-1:0][TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [REG_NUM-1:0]                 busy_q, busy_d;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (CDB_data_valid && CDB_reg_dest != '0) begin
        data_d[CDB_reg_dest] = CDB_data;
        // only the newest producer may retire the rename; stale commits leave busy set
        if (busy_q[CDB_reg_dest] && tag_q[CDB_reg_dest] == CDB_tag)
          busy_d[CDB_reg_dest] = 1'b0;
      end
      if (clear) begin
        busy_d = '0;
        tag_d  = '0;
      end else if (ID_rename_valid && ID_rename_reg != '0) begin
        busy_d[ID_rename_reg] = 1'b1;
        tag_d[ID_rename_reg]  = ID_rename_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // packed as {busy, tag, data}; same-cycle renames are deliberately invisible here
  function automatic logic [TAG_WIDTH+DATA_WIDTH:0] lookup(input logic [REG_WIDTH-1:0] rs);
    lookup = '0;
    if (rs != '0) begin
      if (CDB_data_valid && CDB_reg_dest == rs && busy_q[rs] && tag_q[rs] == CDB_tag)
        lookup = {1'b0, {TAG_WIDTH{1'b0}}, CDB_data};
      else if (busy_q[rs])
        lookup = {1'b1, tag_q[rs], {DATA_WIDTH{1'b0}}};
      else
        lookup = {1'b0, {TAG_WIDTH{1'b0}}, data_q[rs]};
    end
  endfunction

  assign {reg1_busy, reg1_tag, reg1_data} = lookup(ID_rs1);
  assign {reg2_busy, reg2_tag, reg2_data} = lookup(ID_rs2);

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_reg_data  = data_q[dbg_reg_addr];
  assign dbg_busy_mask = busy_q;
`endif

endmodule
